// File: rtl/paralelo_serial.sv
// paralelo_serial: parallel-to-serial transmitter for the physical layer.
// Takes one byte per 8-cycle byte slot and shifts it out MSB-first, one bit per clk_32f cycle.
// After reset (and whenever enable drops) it sends SYNC_COUNT comma bytes so the far-end
// deserializer can frame-align. Once ACTIVE, any slot without valid data carries a comma.
//
// Ports:
//   clk_32f     bit clock, rising edge
//   reset       synchronous, active-low reset
//   enable      link enable; sampled only at byte boundaries
//   data_in     byte to send; taken on the edge ending a ready_out=1 cycle
//   valid_in    qualifies data_in
//   data_out    serial bit (registered)
//   ready_out   high during the last bit of a byte when the next byte comes from data_in
//   active      high while in the ACTIVE state (registered)
//   byte_start  high while data_out carries a byte's MSB
module paralelo_serial #(
  parameter int unsigned SYNC_COUNT = 4,   // legal range 1..15
  parameter logic [7:0]  COMMA      = 8'hBC
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       data_out,
  output logic       ready_out,
  output logic       active,
  output logic       byte_start
);

  typedef enum logic {StSync, StActive} state_e;

  localparam logic [3:0] SyncTarget = 4'(SYNC_COUNT);

  state_e     state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] sync_cnt_q, sync_cnt_d;
  logic       data_out_q, data_out_d;

  logic       boundary;
  logic       sync_done;
  logic [7:0] nb;

  // bit_cnt==7 means the last bit of the current byte is on data_out, so the
  // coming edge loads the next byte.
  assign boundary  = (bit_cnt_q == 3'd7);
  assign sync_done = (sync_cnt_q == SyncTarget);

  assign ready_out  = boundary & enable & ((state_q == StActive) | sync_done);
  assign byte_start = (bit_cnt_q == 3'd0);
  assign data_out   = data_out_q;
  assign active     = (state_q == StActive);

  always_comb begin
    nb         = COMMA;
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    if (boundary) begin
      if (!enable) begin
        // Falling back to SYNC: comma wins even if valid data is offered.
        state_d    = StSync;
        sync_cnt_d = 4'd0;
      end else if ((state_q == StSync) && !sync_done) begin
        sync_cnt_d = sync_cnt_q + 4'd1;
      end else begin
        // Same slot as ready_out: first data slot when leaving SYNC, or steady ACTIVE.
        state_d = StActive;
        if (valid_in) begin
          nb = data_in;
        end
      end
      data_out_d = nb[7];
      sr_d       = {nb[6:0], 1'b0};
      bit_cnt_d  = 3'd0;
    end else begin
      data_out_d = sr_q[7];
      sr_d       = {sr_q[6:0], 1'b0};
      bit_cnt_d  = bit_cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      state_q    <= StSync;
      sr_q       <= 8'd0;
      bit_cnt_q  <= 3'd7;
      sync_cnt_q <= 4'd0;
      data_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      sync_cnt_q <= sync_cnt_d;
      data_out_q <= data_out_d;
    end
  end

endmodule

// File: tb/tb_paralelo_serial.sv
// Testbench for paralelo_serial: per-cycle comparison against a queue-based bit model,
// a table of byte-slot vectors, hand-written corner sequences and a randomized phase.
module tb_paralelo_serial;

  localparam int unsigned SyncN = 4;
  localparam logic [7:0]  Comma = 8'hBC;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       valid;
  logic [7:0] din;
  logic       dout;
  logic       ready;
  logic       act;
  logic       bstart;

  paralelo_serial #(
    .SYNC_COUNT(SyncN),
    .COMMA     (Comma)
  ) dut (
    .clk_32f   (clk),
    .reset     (rst_n),
    .enable    (en),
    .data_in   (din),
    .valid_in  (valid),
    .data_out  (dout),
    .ready_out (ready),
    .active    (act),
    .byte_start(bstart)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of pending serial bits; a new byte is queued whenever it runs dry.
  bit          mq[$];
  int unsigned m_commas;
  bit          m_act;
  bit          m_dout;

  logic [63:0] cap;
  int          ready_seen;

  typedef struct {
    logic       en;
    logic       valid;
    logic [7:0] data;
    logic [7:0] exp_byte;
    logic       exp_act;
  } slot_t;

  slot_t slots[$];

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_vec(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [7:0] nb;
    if (!rst_n) begin
      mq.delete();
      m_commas = 0;
      m_act    = 1'b0;
      m_dout   = 1'b0;
      return;
    end
    if (mq.size() == 0) begin
      if (!en) begin
        nb       = Comma;
        m_commas = 0;
        m_act    = 1'b0;
      end else if (!m_act && m_commas < SyncN) begin
        nb       = Comma;
        m_commas = m_commas + 1;
      end else begin
        m_act = 1'b1;
        nb    = valid ? din : Comma;
      end
      for (int i = 7; i >= 0; i--) mq.push_back(nb[i]);
    end
    m_dout = mq.pop_front();
  endtask

  // One clock: update model on the edge, compare all outputs 1 time unit later.
  task automatic tick();
    logic exp_ready;
    @(posedge clk);
    model_edge();
    #1;
    exp_ready = (mq.size() == 0) && en && (m_act || m_commas == SyncN);
    check_bit("data_out", dout, m_dout);
    check_bit("ready_out", ready, exp_ready);
    check_bit("active", act, m_act);
    check_bit("byte_start", bstart, (mq.size() == 7));
    cap = {cap[62:0], dout};
    if (ready) ready_seen++;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    valid = 1'b0;
    din   = 8'h00;
    cap   = 64'd0;
    ready_seen = 0;

    // Reset state
    repeat (3) tick();
    check_bit("rst_data_out", dout, 1'b0);
    check_bit("rst_ready", ready, 1'b0);
    check_bit("rst_active", act, 1'b0);
    check_bit("rst_byte_start", bstart, 1'b0);

    // SYNC sequence: four commas, ready only in cycle 32
    rst_n = 1'b1;
    ready_seen = 0;
    repeat (32) tick();
    check_vec("sync_commas", {32'd0, cap[31:0]}, {32'd0, {4{Comma}}});
    check_bit("sync_ready_c32", ready, 1'b1);
    check_vec("sync_ready_count", 64'(ready_seen), 64'd1);
    check_bit("sync_active_c32", act, 1'b0);

    // Byte-slot table, starting at the first data slot (E33)
    slots.push_back('{1'b1, 1'b1, 8'h55, 8'h55, 1'b1});
    slots.push_back('{1'b1, 1'b1, 8'hA3, 8'hA3, 1'b1});
    slots.push_back('{1'b1, 1'b1, 8'h0F, 8'h0F, 1'b1});
    slots.push_back('{1'b1, 1'b1, 8'h12, 8'h12, 1'b1});
    slots.push_back('{1'b1, 1'b0, 8'h77, 8'hBC, 1'b1});
    slots.push_back('{1'b1, 1'b1, 8'h34, 8'h34, 1'b1});
    slots.push_back('{1'b0, 1'b1, 8'h99, 8'hBC, 1'b0});
    for (int i = 0; i < 4; i++) slots.push_back('{1'b1, 1'b1, 8'hAA, 8'hBC, 1'b0});
    slots.push_back('{1'b1, 1'b1, 8'hC3, 8'hC3, 1'b1});
    slots.push_back('{1'b0, 1'b0, 8'h00, 8'hBC, 1'b0});
    slots.push_back('{1'b1, 1'b1, 8'h11, 8'hBC, 1'b0});
    slots.push_back('{1'b1, 1'b1, 8'h11, 8'hBC, 1'b0});
    slots.push_back('{1'b0, 1'b1, 8'h22, 8'hBC, 1'b0});
    for (int i = 0; i < 4; i++) slots.push_back('{1'b1, 1'b1, 8'h66, 8'hBC, 1'b0});
    slots.push_back('{1'b1, 1'b1, 8'h5A, 8'h5A, 1'b1});

    foreach (slots[i]) begin
      en    = slots[i].en;
      valid = slots[i].valid;
      din   = slots[i].data;
      repeat (8) tick();
      check_vec($sformatf("slot%0d_byte", i), {56'd0, cap[7:0]}, {56'd0, slots[i].exp_byte});
      check_bit($sformatf("slot%0d_active", i), act, slots[i].exp_act);
    end

    // Enable dropped at bit 3 of 0x81: byte completes, then SYNC restarts from zero
    en = 1'b1; valid = 1'b1; din = 8'h81;
    repeat (4) tick();
    en = 1'b0; valid = 1'b0; din = 8'h00;
    repeat (4) tick();
    check_vec("en_drop_byte", {56'd0, cap[7:0]}, 64'h81);
    check_bit("en_drop_active_hold", act, 1'b1);
    repeat (8) tick();
    check_vec("en_drop_comma", {56'd0, cap[7:0]}, {56'd0, Comma});
    check_bit("en_drop_active_low", act, 1'b0);
    en = 1'b1;
    repeat (32) tick();
    check_vec("reenable_commas", {32'd0, cap[31:0]}, {32'd0, {4{Comma}}});
    check_bit("reenable_ready", ready, 1'b1);
    check_bit("reenable_active_low", act, 1'b0);
    valid = 1'b1; din = 8'h3C;
    repeat (8) tick();
    check_vec("reenable_byte", {56'd0, cap[7:0]}, 64'h3C);
    check_bit("reenable_active", act, 1'b1);

    // Reset at bit 4 of 0xFF
    din = 8'hFF;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    check_bit("midreset_data_out", dout, 1'b0);
    check_bit("midreset_active", act, 1'b0);
    rst_n = 1'b1; valid = 1'b0;
    repeat (32) tick();
    check_vec("midreset_commas", {32'd0, cap[31:0]}, {32'd0, {4{Comma}}});
    check_bit("midreset_active_c32", act, 1'b0);
    tick();
    check_bit("midreset_active_c33", act, 1'b1);

    // Enable held low from reset
    rst_n = 1'b0; en = 1'b0;
    tick();
    rst_n = 1'b1;
    ready_seen = 0;
    repeat (64) tick();
    check_vec("en_low_commas", cap, {8{Comma}});
    check_vec("en_low_ready_count", 64'(ready_seen), 64'd0);
    check_bit("en_low_active", act, 1'b0);

    // Randomized phase against the model
    for (int c = 0; c < 3000; c++) begin
      en    = ($urandom_range(0, 15) != 0);
      valid = 1'($urandom_range(0, 1));
      din   = 8'($urandom);
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/paralelo_serial.md
# paralelo_serial

Parallel-to-serial transmitter for the PCIe-style physical layer. It takes one byte per byte slot from the upstream logic and shifts it out MSB-first, one bit per clk_32f cycle. After reset it sends a fixed run of comma bytes (0xBC) so the far-end deserializer can frame-align and go active. While active, any byte slot without valid data is filled with a comma.

## Interface
Parameters:
- SYNC_COUNT, default 4: number of comma bytes sent in SYNC before entering ACTIVE; legal range 1..15.
- COMMA, default 8'hBC: idle/alignment byte.

Ports:
- clk_32f  input  1  bit clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-low; clock clk_32f.
- enable  input  1  link enable; when low, the block falls back to SYNC at the next byte boundary.
- data_in  input  8  byte to transmit; sampled only on the edge that ends a cycle with ready_out=1.
- valid_in  input  1  qualifies data_in; sampled together with data_in.
- data_out  output  1  serial bit, registered.
- ready_out  output  1  high for exactly the last bit cycle of a byte in which the next byte will be taken from data_in.
- active  output  1  high while the state is ACTIVE, registered.
- byte_start  output  1  high while data_out carries bit 7 (MSB) of a byte.

## Operation
- Registers:
  - sr[7:0] shift register.
  - bit_cnt[2:0]: index of the bit currently on data_out, 0 = MSB, wraps 7→0.
  - sync_cnt[3:0]: commas sent in the current SYNC phase.
  - state: SYNC or ACTIVE.
- Reset (reset==0 at an edge): data_out=0, sr=0, bit_cnt=7, sync_cnt=0, state=SYNC, active=0. Decoded outputs then read ready_out=0 and byte_start=0.
- Edge with bit_cnt!=7: data_out<=sr[7], sr<=sr<<1, bit_cnt<=bit_cnt+1.
- Edge with bit_cnt==7 is a byte boundary. Compute nb (next byte), then data_out<=nb[7], sr<={nb[6:0],1'b0}, bit_cnt<=0.
- nb selection at a boundary:
  - SYNC, enable=0: nb=COMMA, sync_cnt<=0, stay in SYNC.
  - SYNC, enable=1, sync_cnt<SYNC_COUNT: nb=COMMA, sync_cnt<=sync_cnt+1.
  - SYNC, enable=1, sync_cnt==SYNC_COUNT: state<=ACTIVE, active<=1. nb is data_in if valid_in, else COMMA.
  - ACTIVE, enable=1: nb is data_in if valid_in, else COMMA.
  - ACTIVE, enable=0: nb=COMMA, state<=SYNC, active<=0, sync_cnt<=0. data_in is ignored.
- ready_out = (bit_cnt==7) & enable & (state==ACTIVE | sync_cnt==SYNC_COUNT). It never asserts during reset or while bit_cnt is 7 immediately after reset.
- byte_start = (bit_cnt==0).
- data_in and valid_in are don't-care on every edge that is not a boundary with ready_out=1.
- No backpressure: a boundary with ready_out=1 and valid_in=0 sends a comma. The byte offered in that slot is dropped and is not retried.

## Timing
- The first edge after reset release (E1) loads comma 1, and data_out shows its MSB in the cycle after E1.
- With SYNC_COUNT=N and enable held high: commas load at E1, E9, …, E(8N-7). ready_out is high in the cycle between E(8N) and E(8N+1). active rises at E(8N+1), the same edge that loads the first data slot.
- Latency: a byte sampled at boundary edge Eb has its MSB on data_out after Eb and its LSB after Eb+7. Steady throughput is one byte per 8 cycles with no gap.
- Reset mid-byte aborts the byte immediately; data_out=0 from the following cycle.
- An enable change mid-byte has no effect until the next boundary. The byte in flight always completes.
- Simultaneous enable falling and valid_in=1 at a boundary: the comma wins and the data is dropped.

## Test plan
- Reset held low 3 cycles, then high with enable=1, valid_in=0, SYNC_COUNT=4 → data_out carries 10111100 ×4. active rises at E33, then commas continue. ready_out pulses at cycles 32, 40, 48, … only.
- Reset held high, enable=1, byte stream 0x55, 0xA3, 0x0F, each presented with valid_in=1 during its ready_out cycle → serial stream 01010101 10100011 00001111, MSB first, back-to-back. byte_start is high on each MSB.
- In ACTIVE, valid_in=0 for one slot between 0x12 and 0x34 → 00010010 10111100 00110100.
- In ACTIVE, enable dropped at bit 3 of 0x81 → 0x81 completes. Next, SYNC_COUNT commas are sent with active=0, then active returns on re-enable. sync_cnt restarts from 0.
- Reset asserted at bit 4 of 0xFF → next cycle data_out=0, active=0. After release, the full 4-comma SYNC sequence restarts.
- enable held low from reset → endless commas, active=0, ready_out=0 throughout.
